control_unit: RTL

//  Execute-phase sequencer answering the fetch/decode FSM. Latches the ROM instruction on ir_load,

---
 rtl/control_unit_pkg.sv | 59 +++++
 rtl/control_unit_if.sv | 30 +++
 rtl/control_unit_decode.sv | 27 ++
 rtl/control_unit.sv | 134 +++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared CPU definitions: fetch-FSM and execute-unit state codes, opcodes and instruction fields.
// Used by the control unit, the fetch FSM and the ALU.
package control_unit_pkg;

  localparam int DATA_W         = 8;
  localparam int INSTR_W        = 8;
  localparam int CU_MEM_TIMEOUT = 15;

  localparam int OPC_MSB  = 7;
  localparam int OPC_LSB  = 5;
  localparam int RSVD_BIT = 4;
  localparam int RD_MSB   = 3;
  localparam int RD_LSB   = 2;
  localparam int RS_MSB   = 1;
  localparam int RS_LSB   = 0;

  typedef enum logic [1:0] {
    FSM_FETCH   = 2'b00,
    FSM_DECODE  = 2'b01,
    FSM_EXECUTE = 2'b10
  } fsm_state_t;

  typedef enum logic [2:0] {
    CU_IDLE      = 3'b000,
    CU_READ_OPS  = 3'b001,
    CU_ALU       = 3'b010,
    CU_MEM_REQ   = 3'b011,
    CU_MEM_WAIT  = 3'b100,
    CU_WRITEBACK = 3'b101,
    CU_STORE     = 3'b110,
    CU_DONE      = 3'b111
  } cu_state_t;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_MOV = 3'b101,
    OP_LDR = 3'b110,
    OP_STR = 3'b111
  } opcode_t;

  typedef struct packed {
    logic       is_nop;
    logic       is_alu;
    logic       is_ldr;
    logic       is_str;
    opcode_t    opcode;
    logic [1:0] rd;
    logic [1:0] rs;
  } cu_dec_t;

  function automatic opcode_t instr_opcode(input logic [INSTR_W-1:0] instr);
    return opcode_t'(instr[OPC_MSB:OPC_LSB]);
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Handshake bundle between the fetch/decode FSM (master) and the execute control unit (slave).
// Also carries the data-RAM request/ready pair and the register-file/ALU strobes.
interface control_unit_if
  import control_unit_pkg::*;
();

  logic               ir_load;
  logic [INSTR_W-1:0] instr;
  logic               mem_ready;
  logic [2:0]         cu_state;
  logic [1:0]         ra_addr;
  logic [1:0]         rb_addr;
  logic [2:0]         alu_op;
  logic               reg_we;
  logic               wb_sel;
  logic               mem_re;
  logic               mem_we;
  logic               mem_err;

  modport master (
    output ir_load, instr, mem_ready,
    input  cu_state, ra_addr, rb_addr, alu_op, reg_we, wb_sel, mem_re, mem_we, mem_err
  );

  modport slave (
    input  ir_load, instr, mem_ready,
    output cu_state, ra_addr, rb_addr, alu_op, reg_we, wb_sel, mem_re, mem_we, mem_err
  );

endinterface

// File: rtl/control_unit_decode.sv
// Combinational instruction decode: splits an instruction word into opcode class and
// register fields.
module control_unit_decode
  import control_unit_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output cu_dec_t            dec
);

  opcode_t opcode;
  logic    unused_rsvd;

  assign opcode      = instr_opcode(ir);
  assign unused_rsvd = ir[RSVD_BIT];

  always_comb begin
    dec        = '0;
    dec.opcode = opcode;
    dec.rd     = ir[RD_MSB:RD_LSB];
    dec.rs     = ir[RS_MSB:RS_LSB];
    dec.is_nop = (opcode == OP_NOP);
    dec.is_ldr = (opcode == OP_LDR);
    dec.is_str = (opcode == OP_STR);
    dec.is_alu = !(dec.is_nop || dec.is_ldr || dec.is_str);
  end

endmodule

// File: rtl/control_unit.sv
// Execute-phase sequencer: latches the instruction on ir_load and steps register-file, ALU and
// data-RAM strobes through it, ending with a single DONE cycle as the completion handshake.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for ir_load from the fetch FSM
// READ_OPS  | ra/rb addresses presented, dispatch on opcode class
// ALU       | alu_op valid for one cycle
// MEM_REQ   | RAM request raised, timeout counter cleared
// MEM_WAIT  | request held until mem_ready or timeout
// WRITEBACK | one-cycle reg_we, wb_sel picks ALU or RAM data
// STORE     | bookkeeping cycle after a completed store
// DONE      | one-cycle completion code 3'b111 for the fetch FSM
module control_unit
  import control_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = CU_MEM_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset_n,
  control_unit_if.slave bus
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  cu_state_t          state;
  logic [INSTR_W-1:0] ir;
  logic [CNT_W-1:0]   tmo_cnt;
  logic [1:0]         ra_addr;
  logic [1:0]         rb_addr;
  logic [2:0]         alu_op;
  logic               reg_we;
  logic               wb_sel;
  logic               mem_re;
  logic               mem_we;
  logic               mem_err;

  logic [INSTR_W-1:0] dec_src;
  cu_dec_t            dec;

  // In IDLE the incoming word is decoded so READ_OPS outputs are valid on entry.
  assign dec_src = (state == CU_IDLE) ? bus.instr : ir;

  control_unit_decode u_decode (
    .ir  (dec_src),
    .dec (dec)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= CU_IDLE;
      ir      <= '0;
      tmo_cnt <= '0;
      ra_addr <= '0;
      rb_addr <= '0;
      alu_op  <= '0;
      reg_we  <= 1'b0;
      wb_sel  <= 1'b0;
      mem_re  <= 1'b0;
      mem_we  <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      wb_sel <= 1'b0;
      alu_op <= '0;
      unique case (state)
        CU_IDLE: begin
          if (bus.ir_load) begin
            ir      <= bus.instr;
            ra_addr <= dec.rd;
            rb_addr <= dec.rs;
            state   <= CU_READ_OPS;
          end
        end
        CU_READ_OPS: begin
          if (dec.is_nop) begin
            state <= CU_DONE;
          end else if (dec.is_alu) begin
            alu_op <= dec.opcode;
            state  <= CU_ALU;
          end else begin
            mem_re <= dec.is_ldr;
            mem_we <= dec.is_str;
            state  <= CU_MEM_REQ;
          end
        end
        CU_ALU: begin
          reg_we <= 1'b1;
          state  <= CU_WRITEBACK;
        end
        CU_MEM_REQ: begin
          tmo_cnt <= '0;
          state   <= CU_MEM_WAIT;
        end
        CU_MEM_WAIT: begin
          // Ready is checked before the terminal count so a late ready still completes cleanly.
          if (bus.mem_ready) begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            if (dec.is_ldr) begin
              reg_we <= 1'b1;
              wb_sel <= 1'b1;
              state  <= CU_WRITEBACK;
            end else begin
              state <= CU_STORE;
            end
          end else if (tmo_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;
            mem_err <= 1'b1;
            state   <= CU_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        CU_WRITEBACK: state <= CU_DONE;
        CU_STORE:     state <= CU_DONE;
        CU_DONE:      state <= CU_IDLE;
        default:      state <= CU_IDLE;
      endcase
    end
  end

  assign bus.cu_state = state;
  assign bus.ra_addr  = ra_addr;
  assign bus.rb_addr  = rb_addr;
  assign bus.alu_op   = alu_op;
  assign bus.reg_we   = reg_we;
  assign bus.wb_sel   = wb_sel;
  assign bus.mem_re   = mem_re;
  assign bus.mem_we   = mem_we;
  assign bus.mem_err  = mem_err;

endmodule
